mealy_pattern_detector: RTL and testbench

MEALY_PATTERN_DETECTOR -- requirements
Module: mealy_pattern_detector

---
 rtl/mealy_pattern_detector.sv | 107 ++++++++++
 tb/tb_mealy_pattern_detector.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mealy_pattern_detector.sv
// Serial bit-pattern detector with a runtime-loadable pattern, length and overlap mode.
// y is a zero-latency Mealy flag. match_count saturates and cfg_err flags an unusable length.
module mealy_pattern_detector #(
  parameter int                   MAX_LEN         = 8,
  parameter int                   LEN_W           = 4,
  parameter int                   CNT_W           = 8,
  parameter logic [MAX_LEN-1:0]   DEFAULT_PATTERN = MAX_LEN'(4'b1101),
  parameter int                   DEFAULT_LEN     = 4,
  parameter logic                 DEFAULT_OVERLAP = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               x,
  input  logic               x_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               y,
  output logic [CNT_W-1:0]   match_count,
  output logic               cfg_err
);

  localparam int HW = MAX_LEN - 1;

  logic [MAX_LEN-1:0] pat_q,  pat_d;
  logic [LEN_W-1:0]   len_q,  len_d;
  logic               ovl_q,  ovl_d;
  logic [HW-1:0]      hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [CNT_W-1:0]   cnt_q,  cnt_d;
  logic               err_q,  err_d;

  logic [MAX_LEN-1:0] window;
  logic [MAX_LEN-1:0] mask;
  logic               enough_bits;
  logic               match;

  function automatic logic len_valid(input logic [LEN_W-1:0] l);
    return (int'(l) >= 2) && (int'(l) <= MAX_LEN);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
  endfunction

  function automatic logic [LEN_W-1:0] sat_inc_fill(input logic [LEN_W-1:0] f);
    return (f == LEN_W'(MAX_LEN - 1)) ? f : f + LEN_W'(1);
  endfunction

  always_comb begin
    // Newest bit sits at window[0]; pattern bit [len-1] lines up with the oldest bit in use.
    window      = {hist_q, x};
    mask        = ~({MAX_LEN{1'b1}} << len_q);
    enough_bits = ({1'b0, fill_q} + (LEN_W + 1)'(1)) >= {1'b0, len_q};
    match       = enough_bits && len_valid(len_q) && (((window ^ pat_q) & mask) == '0);
    y           = x_valid & match & ~reset & ~cfg_load;

    pat_d  = pat_q;
    len_d  = len_q;
    ovl_d  = ovl_q;
    hist_d = hist_q;
    fill_d = fill_q;
    cnt_d  = cnt_q;
    err_d  = err_q;

    if (cfg_load) begin
      pat_d  = cfg_pattern;
      len_d  = cfg_len;
      ovl_d  = cfg_overlap;
      fill_d = '0;
      cnt_d  = '0;
      err_d  = ~len_valid(cfg_len);
    end else if (x_valid) begin
      hist_d = HW'({hist_q, x});
      fill_d = sat_inc_fill(fill_q);
      if (y) begin
        cnt_d = sat_inc_cnt(cnt_q);
        if (!ovl_q) fill_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pat_q  <= DEFAULT_PATTERN;
      len_q  <= LEN_W'(DEFAULT_LEN);
      ovl_q  <= DEFAULT_OVERLAP;
      hist_q <= '0;
      fill_q <= '0;
      cnt_q  <= '0;
      err_q  <= ~len_valid(LEN_W'(DEFAULT_LEN));
    end else begin
      pat_q  <= pat_d;
      len_q  <= len_d;
      ovl_q  <= ovl_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  assign match_count = cnt_q;
  assign cfg_err     = err_q;

endmodule

// File: tb/tb_mealy_pattern_detector.sv
// Bench for mealy_pattern_detector: directed vector table, hand sequences and random traffic
// checked against a queue-based reference model. A second instance uses a 2-bit counter.
module tb_mealy_pattern_detector;

  logic       clk = 1'b0;
  logic       reset, x, x_valid, cfg_load, cfg_overlap;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       y, y2, cfg_err, cfg_err2;
  logic [7:0] match_count;
  logic [1:0] match_count2;

  int checks = 0;
  int errors = 0;

  mealy_pattern_detector dut (
    .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .y(y), .match_count(match_count), .cfg_err(cfg_err)
  );

  mealy_pattern_detector #(.CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .y(y2), .match_count(match_count2), .cfg_err(cfg_err2)
  );

  always #5 clk = ~clk;

  // Reference model: bits accepted since the last restart, plus the active configuration.
  bit       mq[$];
  bit [7:0] m_pat;
  int       m_len;
  bit       m_ovl;
  int       m_cnt;
  logic     y_s;

  function automatic bit m_len_ok();
    return (m_len >= 2) && (m_len <= 8);
  endfunction

  function automatic bit model_y(bit r, bit ld, bit v, bit xb);
    if (r || ld || !v || !m_len_ok()) return 1'b0;
    if (mq.size() < m_len - 1) return 1'b0;
    if (xb != m_pat[0]) return 1'b0;
    for (int k = 1; k < m_len; k++)
      if (mq[mq.size() - k] != m_pat[k]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int sat(int v, int lim);
    return (v > lim) ? lim : v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive, check y mid-cycle, advance model at the edge, check registered outputs.
  task automatic step(input bit r, input bit ld, input bit v, input bit xb);
    bit ym;
    reset = r; cfg_load = ld; x_valid = v; x = xb;
    #3;
    ym  = model_y(r, ld, v, xb);
    y_s = y;
    check("y", y, ym);
    check("y_sat", y2, ym);
    @(posedge clk);
    if (r) begin
      m_pat = 8'b0000_1101; m_len = 4; m_ovl = 1'b1; mq.delete(); m_cnt = 0;
    end else if (ld) begin
      m_pat = cfg_pattern; m_len = int'(cfg_len); m_ovl = cfg_overlap; mq.delete(); m_cnt = 0;
    end else if (v) begin
      mq.push_back(xb);
      if (mq.size() > 16) void'(mq.pop_front());
      if (ym) begin
        m_cnt++;
        if (!m_ovl) mq.delete();
      end
    end
    #1;
    check("count", match_count, sat(m_cnt, 255));
    check("count_sat", match_count2, sat(m_cnt, 3));
    check("cfg_err", cfg_err, !m_len_ok());
    check("cfg_err_sat", cfg_err2, !m_len_ok());
  endtask

  task automatic load(input logic [7:0] p, input logic [3:0] l, input logic o);
    cfg_pattern = p; cfg_len = l; cfg_overlap = o;
    step(0, 1, 0, 0);
  endtask

  // Stream bits MSB-first; ymask marks the bits that must raise y.
  task automatic run_bits(input logic [15:0] bits, input int n, input logic [15:0] ymask);
    for (int i = 0; i < n; i++) begin
      step(0, 0, 1, bits[n-1-i]);
      check("seq_y", y_s, ymask[n-1-i]);
    end
  endtask

  typedef struct {
    bit rst, ld, v, x, y;
    int cnt;
  } vec_t;

  vec_t tab [0:18];

  initial begin
    reset = 1'b0; x = 1'b0; x_valid = 1'b0; cfg_load = 1'b0;
    cfg_pattern = 8'h00; cfg_len = 4'd0; cfg_overlap = 1'b0;
    m_pat = 8'b0000_1101; m_len = 4; m_ovl = 1'b1; m_cnt = 0;
    @(posedge clk); #1;

    tab = '{
      '{1,0,0,0,0,0},
      '{0,0,1,1,0,0}, '{0,0,1,1,0,0}, '{0,0,1,0,0,0}, '{0,0,1,1,1,1},
      '{1,0,0,0,0,0},
      '{0,0,1,1,0,0}, '{0,0,1,1,0,0}, '{0,0,1,0,0,0}, '{1,0,1,1,0,0}, '{0,0,1,1,0,0},
      '{1,0,0,0,0,0},
      '{0,0,1,1,0,0}, '{0,0,1,1,0,0},
      '{0,0,0,1,0,0}, '{0,0,0,1,0,0}, '{0,0,0,1,0,0},
      '{0,0,1,0,0,0}, '{0,0,1,1,1,1}
    };
    for (int i = 0; i < 19; i++) begin
      step(tab[i].rst, tab[i].ld, tab[i].v, tab[i].x);
      check("tab_y", y_s, tab[i].y);
      check("tab_cnt", match_count, tab[i].cnt);
    end

    // Overlap on, then reload with overlap off and repeat the same stream.
    step(1, 0, 0, 0);
    check("rst_err", cfg_err, 1'b0);
    run_bits(16'b1101101, 7, 16'b0001001);
    check("ovl_cnt", match_count, 2);
    load(8'b0000_1101, 4'd4, 1'b0);
    check("load_clr_cnt", match_count, 0);
    run_bits(16'b1101101, 7, 16'b0001000);
    check("novl_cnt", match_count, 1);

    // Full-width pattern, then an invalid length.
    load(8'b1011_0011, 4'd8, 1'b0);
    run_bits(16'b10110011, 8, 16'b00000001);
    check("len8_cnt", match_count, 1);
    load(8'b1011_0011, 4'd0, 1'b0);
    check("len0_err", cfg_err, 1'b1);
    run_bits(16'b1011001110110011, 16, 16'h0000);
    load(8'b0000_0001, 4'd1, 1'b1);
    check("len1_err", cfg_err, 1'b1);
    run_bits(16'b0101, 4, 16'h0000);

    // cfg_load beats x_valid in the same cycle.
    cfg_pattern = 8'b0000_0011; cfg_len = 4'd2; cfg_overlap = 1'b1;
    step(0, 1, 1, 1);
    check("ld_wins_y", y_s, 1'b0);
    check("ld_err_clr", cfg_err, 1'b0);

    // Counter saturation on the 2-bit instance.
    run_bits(16'b111111, 6, 16'b011111);
    check("sat_cnt", match_count2, 2'd3);
    check("wide_cnt", match_count, 5);

    // Random traffic with occasional reloads and resets.
    for (int i = 0; i < 3000; i++) begin
      bit r, ld, v;
      r  = ($urandom_range(0, 199) == 0);
      ld = ($urandom_range(0, 99) < 2);
      v  = ($urandom_range(0, 99) < 80);
      cfg_pattern = 8'($urandom);
      cfg_overlap = 1'($urandom);
      cfg_len = ($urandom_range(0, 9) < 7) ? 4'($urandom_range(2, 4)) : 4'($urandom_range(0, 15));
      step(r, ld, v, 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
